// File: rtl/attn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | attn_pkg : instruction-word layout and sequencer state encoding      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package attn_pkg;

    localparam int INST_W         = 17;
    localparam int ADDR_W         = 4;

    localparam int INST_OFIFO_RD  = 16;
    localparam int INST_QKADD_LSB = 12;
    localparam int INST_PADD_LSB  = 8;
    localparam int INST_EXECUTE   = 7;
    localparam int INST_LOAD      = 6;
    localparam int INST_QMEM_RD   = 5;
    localparam int INST_QMEM_WR   = 4;
    localparam int INST_KMEM_RD   = 3;
    localparam int INST_KMEM_WR   = 2;
    localparam int INST_PMEM_RD   = 1;
    localparam int INST_PMEM_WR   = 0;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        QWR     = 4'd1,
        KWR     = 4'd2,
        GAP     = 4'd3,
        LOAD    = 4'd4,
        LTAIL   = 4'd5,
        SETTLE1 = 4'd6,
        EXEC    = 4'd7,
        SETTLE2 = 4'd8,
        DRAIN   = 4'd9,
        PRD     = 4'd10,
        DONE    = 4'd11
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_pack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_pack : assembles individual control fields into the inst word   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module inst_pack
    import attn_pkg::*;
(
    input  logic              i_ofifo_rd,
    input  logic [ADDR_W-1:0] i_qkmem_add,
    input  logic [ADDR_W-1:0] i_pmem_add,
    input  logic              i_execute,
    input  logic              i_load,
    input  logic              i_qmem_rd,
    input  logic              i_qmem_wr,
    input  logic              i_kmem_rd,
    input  logic              i_kmem_wr,
    input  logic              i_pmem_rd,
    input  logic              i_pmem_wr,
    output logic [INST_W-1:0] o_inst
);

    always_comb begin
        o_inst                            = '0;
        o_inst[INST_OFIFO_RD]             = i_ofifo_rd;
        o_inst[INST_QKADD_LSB +: ADDR_W]  = i_qkmem_add;
        o_inst[INST_PADD_LSB +: ADDR_W]   = i_pmem_add;
        o_inst[INST_EXECUTE]              = i_execute;
        o_inst[INST_LOAD]                 = i_load;
        o_inst[INST_QMEM_RD]              = i_qmem_rd;
        o_inst[INST_QMEM_WR]              = i_qmem_wr;
        o_inst[INST_KMEM_RD]              = i_kmem_rd;
        o_inst[INST_KMEM_WR]              = i_kmem_wr;
        o_inst[INST_PMEM_RD]              = i_pmem_rd;
        o_inst[INST_PMEM_WR]              = i_pmem_wr;
    end

endmodule
`default_nettype wire

// File: rtl/attn_inst_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | attn_inst_sequencer : autonomous inst/mem_in schedule for fullchip   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module attn_inst_sequencer
    import attn_pkg::*;
#(
    parameter int bw            = 8,
    parameter int pr            = 8,
    parameter int col           = 8,
    parameter int total_cycle   = 8,
    parameter int gap_cycles    = 2,
    parameter int settle_cycles = 10
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [pr*bw-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [pr*bw-1:0]  mem_in,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done,
    output logic [3:0]        phase
);

    // Counter must also reach the idle-phase terminal counts.
    localparam int c_CNT_MAX = max2(max2(col, total_cycle) + 3, max2(settle_cycles, gap_cycles));
    localparam int c_CNT_W   = $clog2(c_CNT_MAX);

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [INST_W-1:0]    r_inst;
    logic [pr*bw-1:0]     r_mem_in;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_adv;
    logic                 w_last;
    logic [c_CNT_W-1:0]   w_limit;
    state_t               w_next;
    state_t               w_state_nxt;
    logic [INST_W-1:0]    w_inst;

    logic                 w_ofifo_rd, w_execute, w_load, w_qmem_rd, w_qmem_wr;
    logic                 w_kmem_rd, w_kmem_wr, w_pmem_rd, w_pmem_wr;
    logic [ADDR_W-1:0]    w_qkmem_add, w_pmem_add;

    assign in_ready = (r_state == QWR) || (r_state == KWR);
    assign w_accept = in_valid && in_ready;

    // w_limit is the terminal count of the current phase; w_adv gates counting.
    always_comb begin
        w_adv   = 1'b1;
        w_limit = '0;
        w_next  = IDLE;
        case (r_state)
            IDLE:    begin w_adv = start;    w_next = QWR; end
            QWR:     begin w_adv = w_accept; w_limit = c_CNT_W'(total_cycle - 1);   w_next = KWR;     end
            KWR:     begin w_adv = w_accept; w_limit = c_CNT_W'(col - 1);           w_next = GAP;     end
            GAP:     begin w_limit = c_CNT_W'(gap_cycles - 1);    w_next = LOAD;    end
            LOAD:    begin w_limit = c_CNT_W'(col + 1);           w_next = LTAIL;   end
            LTAIL:   begin w_limit = c_CNT_W'(1);                 w_next = SETTLE1; end
            SETTLE1: begin w_limit = c_CNT_W'(settle_cycles - 1); w_next = EXEC;    end
            EXEC:    begin w_limit = c_CNT_W'(total_cycle);       w_next = SETTLE2; end
            SETTLE2: begin w_limit = c_CNT_W'(settle_cycles - 1); w_next = DRAIN;   end
            DRAIN:   begin w_limit = c_CNT_W'(total_cycle - 1);   w_next = PRD;     end
            PRD:     begin w_limit = c_CNT_W'(total_cycle);       w_next = DONE;    end
            DONE:    begin w_next = IDLE; end
            default: begin w_next = IDLE; end
        endcase
        w_last      = (r_cnt == w_limit);
        w_state_nxt = (w_adv && w_last) ? w_next : r_state;
    end

    always_comb begin
        w_ofifo_rd  = 1'b0;
        w_execute   = 1'b0;
        w_load      = 1'b0;
        w_qmem_rd   = 1'b0;
        w_qmem_wr   = 1'b0;
        w_kmem_rd   = 1'b0;
        w_kmem_wr   = 1'b0;
        w_pmem_rd   = 1'b0;
        w_pmem_wr   = 1'b0;
        w_qkmem_add = '0;
        w_pmem_add  = '0;
        case (r_state)
            QWR: if (w_accept) begin
                w_qmem_wr   = 1'b1;
                w_qkmem_add = ADDR_W'(r_cnt);
            end
            KWR: if (w_accept) begin
                w_kmem_wr   = 1'b1;
                w_qkmem_add = ADDR_W'(r_cnt);
            end
            // K read lags the load strobe by one cycle to match SRAM latency.
            LOAD: begin
                w_load      = 1'b1;
                w_kmem_rd   = (r_cnt != '0);
                w_qkmem_add = (r_cnt <= c_CNT_W'(1)) ? '0 : ADDR_W'(r_cnt - c_CNT_W'(1));
            end
            LTAIL: w_load = (r_cnt == '0);
            EXEC: begin
                w_execute   = 1'b1;
                w_qmem_rd   = 1'b1;
                w_qkmem_add = ADDR_W'(r_cnt);
            end
            DRAIN: begin
                w_ofifo_rd  = 1'b1;
                w_pmem_wr   = 1'b1;
                w_pmem_add  = ADDR_W'(r_cnt);
            end
            PRD: begin
                w_pmem_rd   = 1'b1;
                w_pmem_add  = (r_cnt > c_CNT_W'(total_cycle)) ? ADDR_W'(total_cycle) : ADDR_W'(r_cnt);
            end
            default: ;
        endcase
    end

    inst_pack u_inst_pack (
        .i_ofifo_rd  (w_ofifo_rd),
        .i_qkmem_add (w_qkmem_add),
        .i_pmem_add  (w_pmem_add),
        .i_execute   (w_execute),
        .i_load      (w_load),
        .i_qmem_rd   (w_qmem_rd),
        .i_qmem_wr   (w_qmem_wr),
        .i_kmem_rd   (w_kmem_rd),
        .i_kmem_wr   (w_kmem_wr),
        .i_pmem_rd   (w_pmem_rd),
        .i_pmem_wr   (w_pmem_wr),
        .o_inst      (w_inst)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_inst   <= '0;
            r_mem_in <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            if (w_adv) begin
                if (w_last) begin
                    r_state <= w_next;
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + c_CNT_W'(1);
                end
            end
            r_inst <= w_inst;
            if (w_accept) begin
                r_mem_in <= in_data;
            end
            r_busy <= (w_state_nxt != IDLE);
            r_done <= (w_state_nxt == DONE);
        end
    end

    assign inst   = r_inst;
    assign mem_in = r_mem_in;
    assign busy   = r_busy;
    assign done   = r_done;
    assign phase  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_attn_inst_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_attn_inst_sequencer : directed self-checking bench                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_attn_inst_sequencer;

    localparam int TC     = 8;
    localparam int COL    = 8;
    localparam int GAPC   = 2;
    localparam int SETTLE = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] mem_in;
    logic [16:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  phase;

    int checks   = 0;
    int failures = 0;

    logic [16:0] q_dec[$];
    int          q_row[$];
    bit          q_val[$];
    int          n_stream;
    logic [63:0] exp_mem;
    int          busy_len;

    attn_inst_sequencer #(
        .bw(8), .pr(8), .col(COL), .total_cycle(TC),
        .gap_cycles(GAPC), .settle_cycles(SETTLE)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_in(mem_in), .inst(inst), .busy(busy), .done(done), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] row_val(input int r);
        return 64'h0123_4567_89ab_cdef ^ (64'(r + 1) * 64'h0101_0101_0101_0101);
    endfunction

    function automatic logic [16:0] iw(input bit of, input int qk, input int pa, input bit ex,
                                       input bit ld, input bit qr, input bit qw, input bit kr,
                                       input bit kw, input bit rd, input bit wr);
        return {of, 4'(qk), 4'(pa), ex, ld, qr, qw, kr, kw, rd, wr};
    endfunction

    task automatic push(input logic [16:0] d, input int r);
        q_dec.push_back(d);
        q_row.push_back(r);
    endtask

    // Expected decision per cycle, starting with the first QWR cycle.
    task automatic build(input int bub_at, input int bub_len);
        int row;
        int stall;
        int a;
        q_dec.delete(); q_row.delete(); q_val.delete();
        row = 0; stall = 0;
        for (int ph = 0; ph < 2; ph++) begin
            a = 0;
            while (a < ((ph == 0) ? TC : COL)) begin
                if (row == bub_at && stall < bub_len) begin
                    stall++;
                    push(17'h0, -1);
                    q_val.push_back(1'b0);
                end else begin
                    push((ph == 0) ? iw(0, a, 0, 0, 0, 0, 1, 0, 0, 0, 0)
                                   : iw(0, a, 0, 0, 0, 0, 0, 0, 1, 0, 0), row);
                    q_val.push_back(1'b1);
                    a++; row++;
                end
            end
        end
        n_stream = q_dec.size();
        for (int c = 0; c < GAPC; c++) push(17'h0, -1);
        for (int c = 0; c <= COL + 1; c++) push(iw(0, (c <= 1) ? 0 : c - 1, 0, 0, 1, 0, 0, c >= 1, 0, 0, 0), -1);
        push(iw(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), -1);
        push(17'h0, -1);
        for (int c = 0; c < SETTLE; c++) push(17'h0, -1);
        for (int c = 0; c <= TC; c++) push(iw(0, c, 0, 1, 0, 1, 0, 0, 0, 0, 0), -1);
        for (int c = 0; c < SETTLE; c++) push(17'h0, -1);
        for (int c = 0; c < TC; c++) push(iw(1, 0, c, 0, 0, 0, 0, 0, 0, 0, 1), -1);
        for (int c = 0; c <= TC; c++) push(iw(0, 0, (c > TC) ? TC : c, 0, 0, 0, 0, 0, 0, 1, 0), -1);
        push(17'h0, -1);
    endtask

    task automatic run_pass(input int bub_at, input int bub_len, input bit spam, input int abort_at);
        int n;
        build(bub_at, bub_len);
        n = q_dec.size();
        busy_len = 0;
        @(negedge clk);
        start = 1'b1;
        for (int j = 0; j < n + 4; j++) begin
            @(negedge clk);
            chk("inst", inst, (j == 0 || j - 1 >= n) ? 17'h0 : q_dec[j-1]);
            if (j >= 1 && j - 1 < n && q_row[j-1] >= 0) exp_mem = row_val(q_row[j-1]);
            chk("mem_in", mem_in, exp_mem);
            chk("in_ready", in_ready, j < n_stream);
            chk("busy", busy, j < n);
            chk("done", done, j == n - 1);
            chk("wr_excl", (int'(inst[4]) + int'(inst[2]) + int'(inst[0])) <= 1, 1);
            chk("exe_load", inst[7] & inst[6], 0);
            if (busy) busy_len++;
            if (j == 0)     chk("phase_qwr", phase, 4'd1);
            if (j == n - 1) chk("phase_done", phase, 4'd11);
            if (j == n + 1) chk("phase_idle", phase, 4'd0);
            if (j == abort_at) begin
                chk("abort_phase_exec", phase, 4'd7);
                reset = 1'b0;
                start = 1'b0;
                in_valid = 1'b0;
                #1;
                chk("abort_inst", inst, 0);
                chk("abort_phase", phase, 0);
                chk("abort_busy", busy, 0);
                chk("abort_mem", mem_in, 0);
                chk("abort_ready", in_ready, 0);
                exp_mem = '0;
                #1 reset = 1'b1;
                return;
            end
            start    = spam && (j == 20 || j == n - 1);
            in_valid = (j < n_stream) ? q_val[j] : 1'b0;
            in_data  = (j < n_stream && q_row[j] >= 0) ? row_val(q_row[j]) : 64'hdead_beef_0bad_f00d;
        end
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        exp_mem  = '0;
        repeat (2) @(negedge clk);
        chk("rst_inst", inst, 0);
        chk("rst_mem", mem_in, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_phase", phase, 0);
        reset = 1'b1;

        run_pass(-1, 0, 1'b0, -1);
        chk("pass_len", busy_len, 77);
        run_pass(5, 3, 1'b0, -1);
        chk("bubble_len", busy_len, 80);
        run_pass(-1, 0, 1'b1, -1);
        chk("spam_len", busy_len, 77);
        run_pass(-1, 0, 1'b0, 45);
        run_pass(-1, 0, 1'b0, -1);
        chk("post_abort_len", busy_len, 77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
